aes_block_io: RTL and testbench
===============================

# aes_block_io

Host-side block adapter for the iterative byte-serial AES encrypt unit. It accepts a 128-bit plaintext over a valid/ready handshake and streams it into the unit as 16 consecutive bytes. It then collects the unit's 16-byte ciphertext burst and presents it as a 128-bit result over a second valid/ready handshake. It sits between the system bus and the encrypt unit, acting as the unit's direct upstream feeder and downstream consumer.

## Interface

Parameters:
- TIMEOUT_CYCLES, 1023: maximum cycles allowed in WAIT before the ciphertext burst must start.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  plaintext offered
- in_ready  output  1  block can accept plaintext
- in_data  input  128  plaintext; byte i = in_data[127-8i -: 8]
- out_valid  output  1  ciphertext available
- out_ready  input  1  consumer accepts ciphertext
- out_data  output  128  ciphertext, same byte order as in_data
- busy  output  1  high in any state other than IDLE
- err  output  1  sticky error flag (timeout or short burst)
- enc_valid_input  output  1  drives the encrypt unit's valid_input
- enc_data_in  output  8  drives the encrypt unit's data_in
- enc_valid_output  input  1  encrypt unit's valid_output
- enc_data_out  input  8  encrypt unit's data_out

## Operation

States are IDLE, LOAD, WAIT, DRAIN and HOLD.

- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready: capture in_data into the shift register, clear err, clear the byte counter, go to LOAD.
- **LOAD**
  - enc_valid_input=1 and enc_data_in = current top byte.
  - Shift left 8 each cycle and increment the 4-bit counter.
  - When the counter reaches 15, go to WAIT and clear the watchdog.
  - enc_valid_output is ignored in this state.
- **WAIT**
  - The watchdog increments each cycle.
  - On enc_valid_output=1: shift enc_data_out into the low byte, set counter=1, go to DRAIN.
  - If the watchdog reaches TIMEOUT_CYCLES-1 with no enc_valid_output: set err and go to IDLE.
- **DRAIN**
  - Each cycle with enc_valid_output=1, shift in a byte and increment the counter.
  - When the 16th byte is captured, go to HOLD.
  - If enc_valid_output=0 before 16 bytes: set err, discard the data, go to IDLE.
- **HOLD**
  - out_valid=1 and out_data is stable.
  - On out_ready: go to IDLE.
- A single 128-bit register serves both serialization and deserialization.
- in_valid held high while busy has no effect. in_data is sampled only at acceptance.
- The watchdog width is $clog2(TIMEOUT_CYCLES+1).

## Timing

- **Reset values:** state=IDLE; in_ready=1; out_valid=0, out_data=0, busy=0, err=0, enc_valid_input=0, enc_data_in=0. Reset asserted mid-operation aborts immediately to these values.
- **Input handshake:** accepted at edge t; byte 0 appears at t+1 and byte 15 at t+16. enc_valid_input is high for exactly 16 contiguous cycles.
- **Output handshake:** out_valid rises one cycle after the edge that captures byte 15.
  - If out_ready is already high, the handshake completes on that first out_valid cycle.
  - in_ready returns the following cycle.
- **No overlap:** no new plaintext is accepted before the output handshake completes. Minimum input-to-input spacing is 16 + unit latency + 16 + 2 cycles.
- **Start timing:** a burst starting on the very first WAIT cycle is legal.
- **Abort timing:** err is set on the same edge as the return to IDLE, and in_ready is high the next cycle.

## Structure

- Package aes_io_pkg holds:
  - the state enum: IDLE, LOAD, WAIT, DRAIN, HOLD;
  - BLOCK_BYTES=16;
  - BYTE_IDX_W=4.
- Optional sub-module aes_byte_shift_reg: a 128-bit register with parallel load, shift-left-by-8 with serial byte in, and top-byte out.
- The top-level integration instantiates aes_block_io beside the encrypt unit and wires the enc_* ports one-to-one.

## Test plan

- **FIPS-197 vector:** key 000102…0f in key memory; in_data=00112233445566778899aabbccddeeff.
  - enc_data_in sequence is 00,11,…,ff on t+1..t+16.
  - out_data=69c4e0d86a7b0430d8cdb78070b4c55a and err=0.
- **Output backpressure:** out_ready held low 50 cycles after out_valid.
  - out_data is stable and in_ready=0 throughout.
  - IDLE is reached the cycle after out_ready rises.
- **Timeout:** stub unit never asserts enc_valid_output, TIMEOUT_CYCLES=20.
  - err=1 and in_ready=1 exactly 20 cycles after LOAD ends.
  - The next accepted block clears err.
- **Short burst:** stub asserts enc_valid_output for 7 cycles only.
  - err=1, out_valid never rises, block returns to IDLE.
- **Reset mid-LOAD:** reset pulsed low at byte 5.
  - All outputs take their reset values while reset is asserted.
  - After release, a fresh FIPS vector completes correctly.
- **in_valid held during busy:** in_valid held high with changing in_data during busy.
  - Only the value at acceptance is encrypted.
  - A second acceptance occurs only after the output handshake.

Source files
------------

// File: rtl/aes_io_pkg.sv
// Shared types and constants for the AES block adapter.
package aes_io_pkg;

    localparam int unsigned BLOCK_BYTES = 16;
    localparam int unsigned BYTE_IDX_W  = 4;
    localparam int unsigned BLOCK_W     = BLOCK_BYTES * 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWait,
        StDrain,
        StHold
    } state_e;

endpackage

// File: rtl/aes_byte_shift_reg.sv
// 128-bit register shared by serialization (top byte out) and
// deserialization (byte shifted in at the bottom).
module aes_byte_shift_reg
    import aes_io_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic [BLOCK_W-1:0] i_load_data,
    input  logic               i_shift,
    input  logic [7:0]         i_byte,
    output logic [BLOCK_W-1:0] o_data,
    output logic [7:0]         o_top_byte
);

    logic [BLOCK_W-1:0] r_data;

    // Clear wins over load, load wins over shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_shift) begin
            r_data <= {r_data[BLOCK_W-9:0], i_byte};
        end
    end

    assign o_data     = r_data;
    assign o_top_byte = r_data[BLOCK_W-1 -: 8];

endmodule

// File: rtl/aes_block_io.sv
// Host-side adapter: 128-bit handshake in, 16-byte stream to the encrypt
// unit, 16-byte burst back, 128-bit handshake out.
module aes_block_io
    import aes_io_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy,
    output logic               err,
    output logic               enc_valid_input,
    output logic [7:0]         enc_data_in,
    input  logic               enc_valid_output,
    input  logic [7:0]         enc_data_out
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [BYTE_IDX_W-1:0] IDX_LAST = BYTE_IDX_W'(BLOCK_BYTES - 1);

    state_e                r_state, w_state_next;
    logic [BYTE_IDX_W-1:0] r_cnt, w_cnt_next;
    logic [WD_W-1:0]       r_wd, w_wd_next;
    logic                  r_err, w_err_next;

    logic                  w_load, w_shift, w_clear;
    logic [7:0]            w_shift_byte;
    logic [BLOCK_W-1:0]    w_data;
    logic [7:0]            w_top_byte;

    aes_byte_shift_reg u_shift_reg (
        .clk         (clk),
        .rst_n       (reset),
        .i_clear     (w_clear),
        .i_load      (w_load),
        .i_load_data (in_data),
        .i_shift     (w_shift),
        .i_byte      (w_shift_byte),
        .o_data      (w_data),
        .o_top_byte  (w_top_byte)
    );

    // State, byte counter, watchdog and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_wd    <= w_wd_next;
            r_err   <= w_err_next;
        end
    end

    // Next-state logic and shift-register control.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wd_next    = r_wd;
        w_err_next   = r_err;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clear      = 1'b0;
        w_shift_byte = 8'h00;

        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_err_next   = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = StLoad;
                end
            end
            StLoad: begin
                // Zeros shift in behind the plaintext; the unit's output is ignored here.
                w_shift    = 1'b1;
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == IDX_LAST) begin
                    w_wd_next    = '0;
                    w_state_next = StWait;
                end
            end
            StWait: begin
                // A burst arriving on the final watchdog cycle still wins.
                if (enc_valid_output) begin
                    w_shift      = 1'b1;
                    w_shift_byte = enc_data_out;
                    w_cnt_next   = BYTE_IDX_W'(1);
                    w_state_next = StDrain;
                end else if (r_wd == WD_LAST) begin
                    w_err_next   = 1'b1;
                    w_state_next = StIdle;
                end else begin
                    w_wd_next = r_wd + 1'b1;
                end
            end
            StDrain: begin
                if (enc_valid_output) begin
                    w_shift      = 1'b1;
                    w_shift_byte = enc_data_out;
                    w_cnt_next   = r_cnt + 1'b1;
                    if (r_cnt == IDX_LAST) begin
                        w_state_next = StHold;
                    end
                end else begin
                    // Burst broke early: drop the partial ciphertext.
                    w_err_next   = 1'b1;
                    w_clear      = 1'b1;
                    w_state_next = StIdle;
                end
            end
            StHold: begin
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs decode directly from state so they are clean straight out of reset.
    always_comb begin
        in_ready        = (r_state == StIdle);
        busy            = (r_state != StIdle);
        out_valid       = (r_state == StHold);
        out_data        = out_valid ? w_data : '0;
        enc_valid_input = (r_state == StLoad);
        enc_data_in     = enc_valid_input ? w_top_byte : 8'h00;
        err             = r_err;
    end

endmodule

// File: tb/tb_aes_block_io.sv
// Self-checking bench for aes_block_io with a behavioural stub encrypt unit.
module tb_aes_block_io;

    localparam int TO = 20;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;
    logic         err;
    logic         enc_valid_input;
    logic [7:0]   enc_data_in;
    logic         enc_valid_output;
    logic [7:0]   enc_data_out;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_block_io #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .busy             (busy),
        .err              (err),
        .enc_valid_input  (enc_valid_input),
        .enc_data_in      (enc_data_in),
        .enc_valid_output (enc_valid_output),
        .enc_data_out     (enc_data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {in_ready, out_valid, busy, err, enc_valid_input, enc_data_in},
              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        check({tag, "_odata"}, out_data, 128'h0);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One transaction. The stub unit answers with burst bytes ct after lat idle
    // WAIT cycles; lat >= TO means it never answers, nburst < 16 truncates it.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input int lat,
                             input int nburst, input int ready_delay, input bit hold_valid,
                             input bit reset_at5);
        logic [127:0] got_in;
        int           nvalid;
        int           k;
        bit           saw_ov;
        bit           stable;

        k = 0;
        while (!in_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        in_data  = pt;
        @(posedge clk); #1;
        if (!hold_valid) in_valid = 1'b0;

        got_in = '0;
        nvalid = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0) check("err_cleared", err, 0);
            if (enc_valid_input) nvalid++;
            got_in = {got_in[119:0], enc_data_in};
            if (hold_valid) in_data = rand128();
            enc_valid_output = 1'($urandom_range(0, 1));
            enc_data_out     = 8'($urandom);
            if (reset_at5 && i == 5) begin
                reset = 1'b0;
                #1;
                check_reset_outputs("rst_mid_load");
                @(posedge clk); #1;
                check_reset_outputs("rst_held");
                reset            = 1'b1;
                in_valid         = 1'b0;
                enc_valid_output = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("load_bytes", got_in, pt);
        check("load_len", nvalid, 16);
        check("load_end", enc_valid_input, 0);
        enc_valid_output = 1'b0;

        if (lat >= TO) begin
            repeat (TO - 1) @(posedge clk);
            #1;
            check("to_pending", {busy, err}, 2'b10);
            @(posedge clk); #1;
            check("to_err", {err, in_ready, out_valid}, 3'b110);
            return;
        end

        for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
        end
        saw_ov = 1'b0;
        for (int i = 0; i < nburst; i++) begin
            enc_valid_output = 1'b1;
            enc_data_out     = ct[127-8*i -: 8];
            if (out_valid) saw_ov = 1'b1;
            @(posedge clk); #1;
        end
        enc_valid_output = 1'b0;

        if (nburst < 16) begin
            check("short_in_drain", {busy, err}, 2'b10);
            @(posedge clk); #1;
            check("short_err", {err, in_ready, out_valid, saw_ov}, 4'b1100);
            return;
        end

        check("ov_rise", {out_valid, in_ready}, 2'b10);
        check("out_data", out_data, ct);
        check("hold_err", err, 0);
        stable = 1'b1;
        for (int i = 0; i < ready_delay; i++) begin
            if (out_data !== ct || !out_valid || in_ready) stable = 1'b0;
            @(posedge clk); #1;
        end
        check("hold_stable", stable, 1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("back_idle", {in_ready, busy, out_valid}, 3'b100);
    endtask

    initial begin
        reset            = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        out_ready        = 1'b0;
        enc_valid_output = 1'b0;
        enc_data_out     = 8'h00;
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        reset = 1'b1;

        // Known-answer block, stub returns the FIPS-197 ciphertext.
        run_block(FIPS_PT, FIPS_CT, 3, 16, 0, 1'b0, 1'b0);
        // Burst on the very first WAIT cycle, then long output backpressure.
        run_block(FIPS_PT, FIPS_CT, 0, 16, 50, 1'b0, 1'b0);
        // Unit never answers.
        run_block(rand128(), rand128(), TO, 16, 0, 1'b0, 1'b0);
        // Next block must clear err.
        run_block(rand128(), rand128(), 2, 16, 1, 1'b0, 1'b0);
        // Burst of only seven bytes.
        run_block(rand128(), rand128(), 1, 7, 0, 1'b0, 1'b0);
        // Reset at byte 5 of LOAD, then a fresh known-answer block.
        run_block(rand128(), rand128(), 0, 16, 0, 1'b0, 1'b1);
        run_block(FIPS_PT, FIPS_CT, 4, 16, 2, 1'b0, 1'b0);
        // in_valid held high with churning in_data through two blocks.
        run_block(rand128(), rand128(), 2, 16, 3, 1'b1, 1'b0);
        run_block(rand128(), rand128(), 1, 16, 0, 1'b1, 1'b0);
        in_valid = 1'b0;
        // Randomized traffic.
        for (int n = 0; n < 8; n++) begin
            run_block(rand128(), rand128(), int'($urandom_range(0, 8)), 16,
                      int'($urandom_range(0, 5)), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
